// File: rtl/button_request_rx.sv
// button_request_rx: synchronize and debounce a raw button into a level, press/release pulses and a sticky request.
module button_request_rx #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       ack,
    output logic       btn_level,
    output logic       press,
    output logic       btn_release,
    output logic       request,
    output logic [7:0] press_count
);
    typedef enum logic [1:0] {LOW_STABLE, LOW_TO_HIGH, HIGH_STABLE, HIGH_TO_LOW} state_t;
    localparam logic [CNT_WIDTH-1:0] CNT_DONE = CNT_WIDTH'(DEBOUNCE_CYCLES);
    state_t state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic sync1, sync2, press_n, release_n;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            state       <= LOW_STABLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            press       <= 1'b0;
            btn_release <= 1'b0;
            request     <= 1'b0;
            press_count <= '0;
        end else begin
            sync1       <= btn_raw;
            sync2       <= sync1;
            state       <= state_n;
            cnt         <= cnt_n;
            btn_level   <= (state_n == HIGH_STABLE) || (state_n == HIGH_TO_LOW);
            press       <= press_n;
            btn_release <= release_n;
            // a press landing together with ack keeps the request alive
            request     <= press_n | (request & (~ack | press));
            press_count <= press_count + 8'(press_n);
        end
    end
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        case (state)
            LOW_STABLE: begin
                state_n = sync2 ? LOW_TO_HIGH : LOW_STABLE;
                cnt_n   = sync2 ? CNT_WIDTH'(1) : '0;
            end
            LOW_TO_HIGH: begin
                if (!sync2) begin
                    state_n = LOW_STABLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_DONE) begin
                    state_n = HIGH_STABLE;
                    cnt_n   = '0;
                    press_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_WIDTH'(1);
                end
            end
            HIGH_STABLE: begin
                state_n = sync2 ? HIGH_STABLE : HIGH_TO_LOW;
                cnt_n   = sync2 ? '0 : CNT_WIDTH'(1);
            end
            HIGH_TO_LOW: begin
                if (sync2) begin
                    state_n = HIGH_STABLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_DONE) begin
                    state_n   = LOW_STABLE;
                    cnt_n     = '0;
                    release_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_WIDTH'(1);
                end
            end
        endcase
    end
endmodule

// File: tb/tb_button_request_rx.sv
// tb_button_request_rx: directed checks of debounce latency, bounce rejection, request/ack and count wrap.
module tb_button_request_rx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_raw = 1'b0;
    logic       ack = 1'b0;
    logic       btn_level, press, btn_release, request;
    logic [7:0] press_count;
    int         n_cmp = 0;
    int         n_err = 0;
    logic       saw_press;

    button_request_rx #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .ack(ack),
        .btn_level(btn_level), .press(press), .btn_release(btn_release),
        .request(request), .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        chk("rst_level", {7'd0, btn_level}, 8'd0);
        chk("rst_press", {7'd0, press}, 8'd0);
        chk("rst_release", {7'd0, btn_release}, 8'd0);
        chk("rst_request", {7'd0, request}, 8'd0);
        chk("rst_count", press_count, 8'd0);

        btn_raw = 1'b1;
        tick(6);
        chk("clean_no_press_e6", {7'd0, press}, 8'd0);
        chk("clean_level_e6", {7'd0, btn_level}, 8'd0);
        tick(1);
        chk("clean_press_e7", {7'd0, press}, 8'd1);
        chk("clean_level_e7", {7'd0, btn_level}, 8'd1);
        chk("clean_request", {7'd0, request}, 8'd1);
        chk("clean_count", press_count, 8'd1);
        tick(1);
        chk("clean_press_once", {7'd0, press}, 8'd0);
        tick(12);
        chk("clean_level_held", {7'd0, btn_level}, 8'd1);

        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("ack_clears", {7'd0, request}, 8'd0);
        btn_raw = 1'b0;
        tick(6);
        chk("rel_no_pulse_e6", {7'd0, btn_release}, 8'd0);
        chk("rel_level_e6", {7'd0, btn_level}, 8'd1);
        tick(1);
        chk("rel_pulse_e7", {7'd0, btn_release}, 8'd1);
        chk("rel_level_e7", {7'd0, btn_level}, 8'd0);
        chk("rel_no_press", {7'd0, press}, 8'd0);
        chk("rel_request", {7'd0, request}, 8'd0);
        tick(1);
        chk("rel_pulse_once", {7'd0, btn_release}, 8'd0);

        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        saw_press = 1'b0;
        for (int s = 0; s < 4; s++) begin
            btn_raw = (s % 2 == 0);
            for (int k = 0; k < 2; k++) begin
                tick(1);
                saw_press |= press;
            end
        end
        btn_raw = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            saw_press |= press;
        end
        chk("bounce_no_press", {7'd0, saw_press}, 8'd0);
        tick(1);
        chk("bounce_press_e7", {7'd0, press}, 8'd1);
        chk("bounce_count", press_count, 8'd1);

        btn_raw = 1'b0;
        tick(10);
        chk("sim_req_before", {7'd0, request}, 8'd1);
        btn_raw = 1'b1;
        tick(7);
        chk("sim_press", {7'd0, press}, 8'd1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("sim_req_kept", {7'd0, request}, 8'd1);
        chk("sim_count", press_count, 8'd2);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("sim_ack_clears", {7'd0, request}, 8'd0);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("idle_ack_req", {7'd0, request}, 8'd0);
        chk("idle_ack_count", press_count, 8'd2);
        chk("idle_ack_level", {7'd0, btn_level}, 8'd1);
        btn_raw = 1'b0;
        tick(10);

        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        for (int p = 0; p < 255; p++) begin
            btn_raw = 1'b1;
            tick(10);
            btn_raw = 1'b0;
            tick(10);
        end
        chk("wrap_count_255", press_count, 8'hff);
        btn_raw = 1'b1;
        tick(7);
        chk("wrap_press", {7'd0, press}, 8'd1);
        chk("wrap_count_0", press_count, 8'd0);
        btn_raw = 1'b0;
        tick(10);
        chk("wrap_request", {7'd0, request}, 8'd1);
        chk("wrap_level", {7'd0, btn_level}, 8'd0);

        btn_raw = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("midrst_level", {7'd0, btn_level}, 8'd0);
        chk("midrst_press", {7'd0, press}, 8'd0);
        chk("midrst_release", {7'd0, btn_release}, 8'd0);
        chk("midrst_request", {7'd0, request}, 8'd0);
        chk("midrst_count", press_count, 8'd0);
        tick(6);
        chk("midrst_no_press_e6", {7'd0, press}, 8'd0);
        tick(1);
        chk("midrst_press_e7", {7'd0, press}, 8'd1);
        chk("midrst_count_1", press_count, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
